instr_encoder: RTL and testbench

- Inverse of the P5 instruction decoder: accepts symbolic instruction requests (kind + register fields + immediate) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and streams the words, one write per word, into instruction memory at consecutive word addresses.
- Used by the test/boot loader to build programs for the P5 core.
- Has a one-entry output register with backpressure, a write-address counter, a capacity limit and sticky error reporting.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 89 ++++++++
 tb/tb_instr_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// slave: encoder side; master: loader / memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit words and streams
// them into instruction memory at consecutive word addresses.
// Ports: clk, reset (sync, active-low), clear (sync restart), bus (request
// handshake + memory write), count (words written), full, done, err (sticky).
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OneW   = (ADDR_W+1)'(1);

    logic            weQ;
    logic [31:0]     wdataQ;
    logic [ADDR_W:0] countQ;
    logic            errQ;
    logic [31:0]     encWord;
    logic            legal;
    logic            inReady;
    logic            accept;
    logic            writeDone;

    always_comb begin
        encWord = '0;
        legal   = 1'b1;
        case (bus.in_kind)
            4'd0: encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd,
                             5'd0, 6'h21};
            4'd1: encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd,
                             5'd0, 6'h23};
            4'd2: encWord = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            4'd3: encWord = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            4'd4: encWord = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            4'd5: encWord = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            4'd6: encWord = {6'h0F, 5'd0, bus.in_rt, bus.in_imm[15:0]};
            4'd7: encWord = {6'h03, bus.in_imm};
            4'd8: encWord = {6'h00, bus.in_rs, 15'd0, 6'h08};
            4'd9: encWord = {6'h02, bus.in_imm};
            default: legal = 1'b0;
        endcase
    end

    // A pending word counts toward capacity so nothing is accepted that
    // could not be written.
    assign full      = (countQ + {{ADDR_W{1'b0}}, weQ}) == DepthW;
    assign done      = (countQ == DepthW) && !weQ;
    assign inReady   = (!weQ || bus.im_ready) && !full && !clear;
    assign accept    = bus.in_valid && inReady;
    assign writeDone = weQ && bus.im_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            weQ    <= 1'b0;
            wdataQ <= '0;
            countQ <= '0;
            errQ   <= 1'b0;
        end else if (clear) begin
            weQ    <= 1'b0;
            countQ <= '0;
        end else begin
            if (writeDone)
                countQ <= countQ + OneW;
            if (accept && legal) begin
                weQ    <= 1'b1;
                wdataQ <= encWord;
            end else if (writeDone) begin
                weQ <= 1'b0;
            end
            if (accept && !legal)
                errQ <= 1'b1;
        end
    end

    // The next write address is always the number of words already written.
    assign bus.im_addr  = countQ[ADDR_W-1:0];
    assign bus.im_we    = weQ;
    assign bus.im_wdata = wdataQ;
    assign bus.in_ready = inReady;
    assign count        = countQ;
    assign err          = errQ;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Drives two instances: full-size and a DEPTH=4 capacity instance.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset;
    logic clear;
    int   tests = 0;
    int   fails = 0;

    instr_encoder_if #(.ADDR_W(10)) a ();
    instr_encoder_if #(.ADDR_W(2))  b ();

    logic [10:0] countA;
    logic        fullA, doneA, errA;
    logic [2:0]  countB;
    logic        fullB, doneB, errB;

    instr_encoder #(.ADDR_W(10), .DEPTH(1024)) dutA (
        .clk(clk), .reset(reset), .clear(clear), .bus(a.slave),
        .count(countA), .full(fullA), .done(doneA), .err(errA)
    );

    instr_encoder #(.ADDR_W(2), .DEPTH(4)) dutB (
        .clk(clk), .reset(reset), .clear(clear), .bus(b.slave),
        .count(countB), .full(fullB), .done(doneB), .err(errB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reqA(input logic [3:0] k, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [25:0] imm);
        a.in_valid = 1'b1;
        a.in_kind  = k;
        a.in_rs    = rs;
        a.in_rt    = rt;
        a.in_rd    = rd;
        a.in_imm   = imm;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        a.in_valid = 1'b0; a.in_kind = '0; a.in_rs = '0; a.in_rt = '0;
        a.in_rd = '0; a.in_imm = '0; a.im_ready = 1'b0;
        b.in_valid = 1'b0; b.in_kind = '0; b.in_rs = '0; b.in_rt = '0;
        b.in_rd = '0; b.in_imm = '0; b.im_ready = 1'b0;
        tick();
        tick();
        chk("rst_we", {31'd0, a.im_we}, 32'd0);
        chk("rst_addr", {22'd0, a.im_addr}, 32'd0);
        chk("rst_wdata", a.im_wdata, 32'd0);
        chk("rst_count", {21'd0, countA}, 32'd0);
        chk("rst_err", {31'd0, errA}, 32'd0);
        chk("rst_full", {31'd0, fullA}, 32'd0);
        reset = 1'b1;
        tick();

        // addu with 1-cycle latency
        reqA(4'd0, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
        a.im_ready = 1'b1;
        #1;
        chk("addu_rdy", {31'd0, a.in_ready}, 32'd1);
        tick();
        a.in_valid = 1'b0;
        chk("addu_we", {31'd0, a.im_we}, 32'd1);
        chk("addu_addr", {22'd0, a.im_addr}, 32'd0);
        chk("addu_data", a.im_wdata, 32'h00221821);
        tick();
        chk("addu_cnt", {21'd0, countA}, 32'd1);
        chk("addu_we0", {31'd0, a.im_we}, 32'd0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cnt", {21'd0, countA}, 32'd0);

        // back-to-back stream, one word per cycle
        reqA(4'd2, 5'd0, 5'd1, 5'd9, 26'h0001234);
        tick();
        chk("ori_data", a.im_wdata, 32'h34011234);
        chk("ori_addr", {22'd0, a.im_addr}, 32'd0);
        chk("ori_rdy", {31'd0, a.in_ready}, 32'd1);
        reqA(4'd3, 5'd1, 5'd2, 5'd9, 26'h0000004);
        tick();
        chk("lw_data", a.im_wdata, 32'h8C220004);
        chk("lw_addr", {22'd0, a.im_addr}, 32'd1);
        chk("lw_rdy", {31'd0, a.in_ready}, 32'd1);
        reqA(4'd4, 5'd1, 5'd2, 5'd9, 26'h0000008);
        tick();
        chk("sw_data", a.im_wdata, 32'hAC220008);
        chk("sw_addr", {22'd0, a.im_addr}, 32'd2);
        reqA(4'd6, 5'd7, 5'd5, 5'd9, 26'h000FFFF);
        tick();
        a.in_valid = 1'b0;
        chk("lui_data", a.im_wdata, 32'h3C05FFFF);
        chk("lui_addr", {22'd0, a.im_addr}, 32'd3);
        chk("lui_we", {31'd0, a.im_we}, 32'd1);
        tick();
        chk("b2b_cnt", {21'd0, countA}, 32'd4);
        chk("b2b_we0", {31'd0, a.im_we}, 32'd0);

        // beq held by backpressure, jr follows
        a.im_ready = 1'b0;
        reqA(4'd5, 5'd1, 5'd2, 5'd0, 26'h000FFFF);
        tick();
        reqA(4'd8, 5'd31, 5'd7, 5'd7, 26'h3FFFFFF);
        for (int i = 0; i < 3; i++) begin
            chk("beq_data", a.im_wdata, 32'h1022FFFF);
            chk("beq_addr", {22'd0, a.im_addr}, 32'd4);
            chk("beq_rdy0", {31'd0, a.in_ready}, 32'd0);
            tick();
        end
        a.im_ready = 1'b1;
        #1;
        chk("jr_rdy", {31'd0, a.in_ready}, 32'd1);
        tick();
        a.in_valid = 1'b0;
        chk("jr_data", a.im_wdata, 32'h03E00008);
        chk("jr_addr", {22'd0, a.im_addr}, 32'd5);
        chk("jr_cnt", {21'd0, countA}, 32'd5);
        tick();
        chk("jr_cnt2", {21'd0, countA}, 32'd6);

        // illegal kind then jal
        reqA(4'd12, 5'd1, 5'd1, 5'd1, 26'h0000001);
        tick();
        a.in_valid = 1'b0;
        chk("ill_err", {31'd0, errA}, 32'd1);
        chk("ill_we", {31'd0, a.im_we}, 32'd0);
        chk("ill_cnt", {21'd0, countA}, 32'd6);
        reqA(4'd7, 5'd3, 5'd3, 5'd3, 26'h0C00000);
        tick();
        a.in_valid = 1'b0;
        chk("jal_data", a.im_wdata, 32'h0CC00000);
        chk("jal_addr", {22'd0, a.im_addr}, 32'd6);
        tick();
        chk("jal_cnt", {21'd0, countA}, 32'd7);
        chk("jal_err", {31'd0, errA}, 32'd1);

        // clear keeps err, beats a completing write
        reqA(4'd9, 5'd0, 5'd0, 5'd0, 26'h0000010);
        tick();
        a.in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrw_cnt", {21'd0, countA}, 32'd0);
        chk("clrw_we", {31'd0, a.im_we}, 32'd0);
        chk("clrw_err", {31'd0, errA}, 32'd1);

        // reset during stalled write
        a.im_ready = 1'b0;
        reqA(4'd4, 5'd1, 5'd2, 5'd0, 26'h0000008);
        tick();
        a.in_valid = 1'b0;
        chk("stall_we", {31'd0, a.im_we}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rmid_we", {31'd0, a.im_we}, 32'd0);
        chk("rmid_cnt", {21'd0, countA}, 32'd0);
        chk("rmid_err", {31'd0, errA}, 32'd0);
        chk("rmid_data", a.im_wdata, 32'd0);

        // clear together with an offered request
        a.im_ready = 1'b1;
        reqA(4'd0, 5'd1, 5'd2, 5'd3, 26'h0);
        clear = 1'b1;
        #1;
        chk("clra_rdy", {31'd0, a.in_ready}, 32'd0);
        tick();
        clear = 1'b0;
        a.in_valid = 1'b0;
        chk("clra_we", {31'd0, a.im_we}, 32'd0);
        chk("clra_cnt", {21'd0, countA}, 32'd0);

        // capacity on DEPTH=4 instance
        b.im_ready = 1'b1;
        b.in_valid = 1'b1;
        b.in_kind  = 4'd0;
        b.in_rs    = 5'd1;
        b.in_rt    = 5'd2;
        b.in_rd    = 5'd3;
        tick();
        tick();
        tick();
        chk("cap_cnt2", {29'd0, countB}, 32'd2);
        chk("cap_full0", {31'd0, fullB}, 32'd0);
        chk("cap_rdy1", {31'd0, b.in_ready}, 32'd1);
        tick();
        chk("cap_full", {31'd0, fullB}, 32'd1);
        chk("cap_rdy0", {31'd0, b.in_ready}, 32'd0);
        chk("cap_addr3", {30'd0, b.im_addr}, 32'd3);
        chk("cap_done0", {31'd0, doneB}, 32'd0);
        tick();
        chk("cap_cnt4", {29'd0, countB}, 32'd4);
        chk("cap_done", {31'd0, doneB}, 32'd1);
        chk("cap_we0", {31'd0, b.im_we}, 32'd0);
        chk("cap_full4", {31'd0, fullB}, 32'd1);
        tick();
        chk("cap_hold", {29'd0, countB}, 32'd4);
        chk("cap_rdyh", {31'd0, b.in_ready}, 32'd0);
        b.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
